// File: rtl/shift_word_collector_pkg.sv
// Shared definitions for the shift word collector.
//   DIR_RIGHT / DIR_LEFT : values of the mode input / stored direction tag
//   word_t               : {dir, data} record for the default 4-bit register
//   clog2                : ceil(log2(value)), used to size counters and pointers
package shift_word_collector_pkg;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    localparam int DEF_WIDTH = 4;

    typedef struct packed {
        logic                 dir;
        logic [DEF_WIDTH-1:0] data;
    } word_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_word_collector_sync_fifo.sv
// Show-ahead circular FIFO with a drop-on-full rule.
//   push/wdata : write request; accepted if not full or a pop happens this cycle
//   pop_req    : consumer ready; a pop only happens when not empty
//   rdata      : head entry; while empty it holds the last popped head (0 after reset)
//   empty/full/count : occupancy status
//   drop       : combinational, high when a push is refused because the FIFO is full
module shift_word_collector_sync_fifo
    import shift_word_collector_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 5,
    localparam int CNT_W  = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop_req,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              drop
);

    localparam int PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] hold_q;
    logic              pop;
    logic              push_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count   = cnt_q;
    assign pop     = pop_req & ~empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok = push & (~full | pop);
    assign drop    = push & ~push_ok;
    assign rdata   = empty ? hold_q : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by overflow
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // storage is only read while the entry is valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/shift_word_collector.sv
// Counts shifts of an external bidirectional shift register and, once WIDTH
// shifts in one direction have completed, snapshots its parallel output the
// following cycle and queues {dir, word} in a FIFO.
//   clk, reset (async, active low)
//   shift_en, mode : a shift happens at the end of this cycle in direction mode
//   par_in         : shift register parallel output
//   out_ready      : consumer takes the head word
//   ovf_clr        : clears the sticky overflow flag
//   out_data/out_valid/count/full : FIFO head and status
//   overflow       : sticky, a completed word was dropped
//   dir_err        : one-cycle pulse, a frame was aborted by a direction change
module shift_word_collector
    import shift_word_collector_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        shift_en,
    input  logic                        mode,
    input  logic [WIDTH-1:0]            par_in,
    input  logic                        out_ready,
    input  logic                        ovf_clr,
    output logic [WIDTH:0]              out_data,
    output logic                        out_valid,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        full,
    output logic                        overflow,
    output logic                        dir_err
);

    localparam int CNT_W = (WIDTH > 1) ? clog2(WIDTH) : 1;

    typedef enum logic {COLLECT, PENDING} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             frame_dir, frame_dir_n;
    logic             dir_err_n;
    logic             push;
    logic             drop;
    logic             empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= COLLECT;
            cnt       <= '0;
            frame_dir <= DIR_LEFT;
            dir_err   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            frame_dir <= frame_dir_n;
            dir_err   <= dir_err_n;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // PENDING lasts exactly one cycle: par_in then shows the completed word.
    // Shifts in that cycle still count toward the next word.
    always_comb begin
        state_n     = COLLECT;
        cnt_n       = cnt;
        frame_dir_n = frame_dir;
        dir_err_n   = 1'b0;
        if (shift_en) begin
            if (cnt == '0) begin
                frame_dir_n = mode;
                if (WIDTH == 1) state_n = PENDING;
                else            cnt_n   = CNT_W'(1);
            end else if (mode != frame_dir) begin
                // abort the partial word; this shift opens a fresh frame
                dir_err_n   = 1'b1;
                frame_dir_n = mode;
                cnt_n       = CNT_W'(1);
            end else if (cnt == CNT_W'(WIDTH - 1)) begin
                cnt_n   = '0;
                state_n = PENDING;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    assign push      = (state == PENDING);
    assign out_valid = ~empty;

    shift_word_collector_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop_req (out_ready),
        .wdata   ({frame_dir, par_in}),
        .rdata   (out_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .drop    (drop)
    );

endmodule

// File: tb/tb_shift_word_collector.sv
module tb_shift_word_collector;
    import shift_word_collector_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             shift_en = 1'b0;
    logic             mode = 1'b0;
    logic             sin = 1'b0;
    logic             out_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [WIDTH-1:0] sreg = '0;
    logic [WIDTH:0]   out_data;
    logic             out_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;
    logic             dir_err;

    int total = 0;
    int bad   = 0;

    shift_word_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .mode      (mode),
        .par_in    (sreg),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .dir_err   (dir_err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] v, input logic m,
                                                 input logic s);
        if (m == DIR_RIGHT) return {s, v[WIDTH-1:1]};
        return {v[WIDTH-2:0], s};
    endfunction

    // the external shift register being observed
    always @(posedge clk) if (shift_en) sreg <= shifted(sreg, mode, sin);

    // ---------------- behavioural model ----------------
    word_t m_q[$];
    word_t m_last = '0;
    word_t m_pend_word = '0;
    int    m_len = 0;
    logic  m_dir = 1'b0;
    logic  m_pend = 1'b0;
    logic  m_ovf = 1'b0;
    logic  m_derr = 1'b0;

    task automatic model_step();
        if (!reset) begin
            m_q.delete();
            m_last = '0; m_len = 0; m_dir = 1'b0;
            m_pend = 1'b0; m_ovf = 1'b0; m_derr = 1'b0;
        end else begin
            if (out_ready && m_q.size() > 0) m_last = m_q.pop_front();
            if (m_pend && m_q.size() >= DEPTH) m_ovf = 1'b1;
            else if (ovf_clr)                  m_ovf = 1'b0;
            if (m_pend && m_q.size() < DEPTH)  m_q.push_back(m_pend_word);
            m_pend = 1'b0;
            m_derr = 1'b0;
            if (shift_en) begin
                if (m_len == 0) begin
                    m_dir = mode; m_len = 1;
                end else if (mode != m_dir) begin
                    m_derr = 1'b1; m_dir = mode; m_len = 1;
                end else begin
                    m_len++;
                end
                if (m_len == WIDTH) begin
                    m_len = 0;
                    m_pend = 1'b1;
                    m_pend_word = '{dir: m_dir, data: shifted(sreg, mode, sin)};
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        chk("valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("data", 32'(out_data), 32'((m_q.size() != 0) ? m_q[0] : m_last));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("dir_err", 32'(dir_err), 32'(m_derr));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic se, input logic md, input logic sn, input logic rdy,
                       input logic clr);
        shift_en = se; mode = md; sin = sn; out_ready = rdy; ovf_clr = clr;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        logic [3:0] pat;
        logic       cur;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        reset = 1'b1;
        idle(1'b0);

        // four right shifts of 1s: 1000,1100,1110,1111
        repeat (4) cyc(1'b1, DIR_RIGHT, 1'b1, 1'b0, 1'b0);
        chk("t1_before_push", 32'(out_valid), 32'(0));
        idle(1'b0);
        chk("t1_valid", 32'(out_valid), 32'(1));
        chk("t1_data", 32'(out_data), 32'(5'b1_1111));
        chk("t1_count", 32'(count), 32'(1));
        idle(1'b1);

        // four left shifts building 0101, held until ready
        pat = 4'b0101;
        for (int i = 3; i >= 0; i--) cyc(1'b1, DIR_LEFT, pat[i], 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        chk("t2_data", 32'(out_data), 32'(5'b0_0101));
        chk("t2_valid", 32'(out_valid), 32'(1));
        idle(1'b1);
        chk("t2_empty", 32'(out_valid), 32'(0));
        chk("t2_count", 32'(count), 32'(0));

        // direction change mid-word aborts the frame
        repeat (2) cyc(1'b1, DIR_RIGHT, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, DIR_LEFT, 1'b1, 1'b0, 1'b0);
        chk("t3_dir_err", 32'(dir_err), 32'(1));
        cyc(1'b1, DIR_LEFT, 1'b0, 1'b0, 1'b0);
        chk("t3_dir_err_end", 32'(dir_err), 32'(0));
        cyc(1'b1, DIR_LEFT, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, DIR_LEFT, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("t3_count", 32'(count), 32'(1));
        chk("t3_data", 32'(out_data), 32'(5'b0_1010));
        idle(1'b1);

        // five words into a four-entry FIFO
        repeat (20) cyc(1'b1, DIR_RIGHT, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle(1'b0);
        chk("t4_count", 32'(count), 32'(4));
        chk("t4_full", 32'(full), 32'(1));
        chk("t4_ovf", 32'(overflow), 32'(1));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_ovf_clr", 32'(overflow), 32'(0));

        // push and pop together on a full FIFO
        repeat (4) cyc(1'b1, DIR_LEFT, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle(1'b1);
        chk("t5_count", 32'(count), 32'(4));
        chk("t5_ovf", 32'(overflow), 32'(0));
        repeat (4) idle(1'b1);
        chk("t5_drained", 32'(count), 32'(0));

        // reset during the pending capture cycle
        repeat (4) cyc(1'b1, DIR_RIGHT, 1'b1, 1'b0, 1'b0);
        shift_en = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        repeat (2) idle(1'b0);
        chk("t6_count", 32'(count), 32'(0));
        chk("t6_valid", 32'(out_valid), 32'(0));
        repeat (4) cyc(1'b1, DIR_LEFT, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("t6_word", 32'(out_data), 32'(5'b0_1111));
        idle(1'b1);

        // randomized traffic
        cur = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) cur = ~cur;
            if ($urandom_range(0, 699) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
                @(negedge clk);
            end
            cyc(1'($urandom_range(0, 3) != 0), cur, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
